// File: rtl/mips_core.sv
// mips_core: single-cycle MIPS-I subset processor (ALU, branch/jump, byte/half/word load-store).
// Latency: one instruction per clk; GRF/PC commit at the rising edge after combinational decode.
// Backpressure: none; external instruction/data memories answer combinationally every cycle.
// Ports: clk/reset (sync, active-low), interrupt; i_inst_* fetch port; m_data_* data port with
//        per-byte enables; macroscopic_pc and m_/w_inst_addr trace PCs; w_grf_* register-write trace.
// Optional: define INT_EN to add EPC/EXL, interrupt entry at EXC_ENTRY and eret.
module mips_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    output logic [31:0] macroscopic_pc,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU  = 6'h25, OP_SB   = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29, OP_SW   = 6'h2b;
    localparam logic [5:0] F_SLL    = 6'h00, F_JR    = 6'h08, F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU   = 6'h23, F_AND   = 6'h24, F_OR    = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2a, F_SLTU  = 6'h2b;

    logic [31:0] pc_q, pc_d, pc_next;
    logic [31:0] grf_q [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] rs_val, rt_val, imm_sext, imm_zext, pc_plus4, ea;
    logic [31:0] br_target, j_target;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, st_data;
    logic [3:0]  st_be;
    logic        int_take, squash;

    assign op       = i_inst_rdata[31:26];
    assign rs       = i_inst_rdata[25:21];
    assign rt       = i_inst_rdata[20:16];
    assign rd       = i_inst_rdata[15:11];
    assign shamt    = i_inst_rdata[10:6];
    assign funct    = i_inst_rdata[5:0];
    assign imm      = i_inst_rdata[15:0];

    // $0 is gated on read so it reads zero regardless of array contents.
    assign rs_val    = (rs == 5'd0) ? 32'd0 : grf_q[rs];
    assign rt_val    = (rt == 5'd0) ? 32'd0 : grf_q[rt];
    assign imm_sext  = {{16{imm[15]}}, imm};
    assign imm_zext  = {16'd0, imm};
    assign pc_plus4  = pc_q + 32'd4;
    assign ea        = rs_val + imm_sext;
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], i_inst_rdata[25:0], 2'b00};

    // Lane extraction from the word-aligned read data.
    assign ld_half = ea[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    always_comb begin
        case (ea[1:0])
            2'd0:    ld_byte = m_data_rdata[7:0];
            2'd1:    ld_byte = m_data_rdata[15:8];
            2'd2:    ld_byte = m_data_rdata[23:16];
            default: ld_byte = m_data_rdata[31:24];
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rt;
        wr_data = 32'd0;
        st_be   = 4'b0000;
        st_data = rt_val;
        pc_d    = pc_plus4;
        case (op)
            OP_RTYPE: begin
                wr_addr = rd;
                case (funct)
                    F_ADDU: begin wr_en = 1'b1; wr_data = rs_val + rt_val; end
                    F_SUBU: begin wr_en = 1'b1; wr_data = rs_val - rt_val; end
                    F_AND:  begin wr_en = 1'b1; wr_data = rs_val & rt_val; end
                    F_OR:   begin wr_en = 1'b1; wr_data = rs_val | rt_val; end
                    F_SLT:  begin wr_en = 1'b1; wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
                    F_SLTU: begin wr_en = 1'b1; wr_data = {31'd0, rs_val < rt_val}; end
                    F_SLL:  begin wr_en = 1'b1; wr_data = rt_val << shamt; end
                    F_JR:   pc_d = rs_val;
                    default: ;
                endcase
            end
            OP_ADDIU: begin wr_en = 1'b1; wr_data = rs_val + imm_sext; end
            OP_ANDI:  begin wr_en = 1'b1; wr_data = rs_val & imm_zext; end
            OP_ORI:   begin wr_en = 1'b1; wr_data = rs_val | imm_zext; end
            OP_LUI:   begin wr_en = 1'b1; wr_data = {imm, 16'd0}; end
            OP_BEQ:   if (rs_val == rt_val) pc_d = br_target;
            OP_BNE:   if (rs_val != rt_val) pc_d = br_target;
            OP_J:     pc_d = j_target;
            OP_JAL:   begin pc_d = j_target; wr_en = 1'b1; wr_addr = 5'd31; wr_data = pc_plus4; end
            OP_LW:    begin wr_en = 1'b1; wr_data = m_data_rdata; end
            OP_LH:    begin wr_en = 1'b1; wr_data = {{16{ld_half[15]}}, ld_half}; end
            OP_LHU:   begin wr_en = 1'b1; wr_data = {16'd0, ld_half}; end
            OP_LB:    begin wr_en = 1'b1; wr_data = {{24{ld_byte[7]}}, ld_byte}; end
            OP_LBU:   begin wr_en = 1'b1; wr_data = {24'd0, ld_byte}; end
            OP_SW:    st_be = 4'b1111;
            OP_SH:    begin st_be = ea[1] ? 4'b1100 : 4'b0011; st_data = {2{rt_val[15:0]}}; end
            OP_SB:    begin st_be = 4'b0001 << ea[1:0]; st_data = {4{rt_val[7:0]}}; end
            default: ;
        endcase
    end

`ifdef INT_EN
    localparam logic [31:0] ERET = 32'h4200_0018;
    logic [31:0] epc_q;
    logic        exl_q;
    logic        is_eret;

    assign is_eret  = (i_inst_rdata == ERET);
    assign int_take = interrupt & ~exl_q;

    always_comb begin
        pc_next = pc_d;
        if (int_take)     pc_next = EXC_ENTRY;
        else if (is_eret) pc_next = epc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            epc_q <= 32'd0;
            exl_q <= 1'b0;
        end else if (int_take) begin
            epc_q <= pc_q;
            exl_q <= 1'b1;
        end else if (is_eret) begin
            exl_q <= 1'b0;
        end
    end
`else
    logic unused_irq;
    assign unused_irq = interrupt;
    assign int_take   = 1'b0;
    assign pc_next    = int_take ? EXC_ENTRY : pc_d;
`endif

    // A squashed instruction (reset or interrupt entry) must not touch memory or the GRF.
    assign squash        = int_take | ~reset;
    assign w_grf_we      = wr_en & (wr_addr != 5'd0) & ~squash;
    assign w_grf_addr    = wr_addr;
    assign w_grf_wdata   = wr_data;
    assign m_data_byteen = squash ? 4'b0000 : st_be;
    assign m_data_wdata  = st_data;
    assign m_data_addr   = ea;

    assign macroscopic_pc = pc_q;
    assign i_inst_addr    = pc_q;
    assign m_inst_addr    = pc_q;
    assign w_inst_addr    = pc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < 32; i++) grf_q[i] <= 32'd0;
        end else begin
            pc_q <= pc_next;
            if (w_grf_we) grf_q[w_grf_addr] <= w_grf_wdata;
        end
    end
endmodule

// File: tb/tb_mips_core.sv
// tb_mips_core: drives directed and random instruction streams into mips_core and compares
// every cycle's trace/memory outputs with an instruction-level reference model.
module tb_mips_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        interrupt = 1'b0;
    logic [31:0] i_inst_rdata = 32'd0;
    logic [31:0] m_data_rdata;
    logic [31:0] macroscopic_pc, i_inst_addr, m_data_addr, m_data_wdata;
    logic [31:0] m_inst_addr, w_grf_wdata, w_inst_addr;
    logic [3:0]  m_data_byteen;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;

    mips_core dut (
        .clk(clk), .reset(reset), .interrupt(interrupt),
        .macroscopic_pc(macroscopic_pc), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
        .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .w_grf_we(w_grf_we),
        .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr)
    );

    always #5 clk = ~clk;

    // External data memory: 64 words, combinational read, byte-enabled write on the edge.
    logic [31:0] env_mem [64];
    assign m_data_rdata = env_mem[m_data_addr[7:2]];
    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (m_data_byteen[i]) env_mem[m_data_addr[7:2]][8*i +: 8] <= m_data_wdata[8*i +: 8];

    // Reference model state: architectural registers, PC and a byte-addressed memory image.
    logic [31:0] r_regs [32];
    logic [31:0] r_pc, r_epc;
    logic        r_exl;
    logic [7:0]  r_mem [256];

    int tests = 0;
    int fails = 0;
    logic        o_we;
    logic [31:0] o_wdata, o_mwdata;
    logic [3:0]  o_be;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] s, t, d, sa, input logic [5:0] fn);
        return {6'h00, s, t, d, sa, fn};
    endfunction
    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    // Executes one instruction: drives it, checks the DUT's combinational outputs against the
    // model's prediction, advances the model, and returns at the next falling edge.
    task automatic run(input logic [31:0] inst, input logic irq);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sa, wr;
        logic [31:0] a, b, se, ze, ea, pc4, npc, wv, wd;
        logic [3:0]  be;
        logic [7:0]  ba, wb, hb;
        logic [15:0] h;
        logic        ld, take, leave;
        i_inst_rdata = inst;
        interrupt    = irq;
        #1;
        op = inst[31:26]; rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11];
        sa = inst[10:6];  fn = inst[5:0];
        a = r_regs[rs]; b = r_regs[rt];
        se = {{16{inst[15]}}, inst[15:0]}; ze = {16'h0, inst[15:0]};
        ea = a + se; ba = ea[7:0]; wb = ba & 8'hfc; hb = ba & 8'hfe;
        pc4 = r_pc + 32'd4; npc = pc4;
        wr = 5'd0; wv = 32'd0; be = 4'd0; wd = 32'd0; ld = 1'b0; take = 1'b0; leave = 1'b0;
`ifdef INT_EN
        take = irq && !r_exl;
`endif
        case (op)
            6'h00: case (fn)
                6'h21: begin wr = rd; wv = a + b; end
                6'h23: begin wr = rd; wv = a - b; end
                6'h24: begin wr = rd; wv = a & b; end
                6'h25: begin wr = rd; wv = a | b; end
                6'h2a: begin wr = rd; wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                6'h2b: begin wr = rd; wv = (a < b) ? 32'd1 : 32'd0; end
                6'h00: begin wr = rd; wv = b << sa; end
                6'h08: npc = a;
                default: ;
            endcase
            6'h09: begin wr = rt; wv = a + se; end
            6'h0c: begin wr = rt; wv = a & ze; end
            6'h0d: begin wr = rt; wv = a | ze; end
            6'h0f: begin wr = rt; wv = ze * 32'd65536; end
            6'h04: if (a == b) npc = pc4 + se * 32'd4;
            6'h05: if (a != b) npc = pc4 + se * 32'd4;
            6'h02: npc = {pc4[31:28], inst[25:0], 2'b00};
            6'h03: begin npc = {pc4[31:28], inst[25:0], 2'b00}; wr = 5'd31; wv = pc4; end
            6'h23: begin ld = 1; wr = rt; wv = {r_mem[wb+3], r_mem[wb+2], r_mem[wb+1], r_mem[wb]}; end
            6'h21: begin ld = 1; wr = rt; h = {r_mem[hb+1], r_mem[hb]}; wv = {{16{h[15]}}, h}; end
            6'h25: begin ld = 1; wr = rt; h = {r_mem[hb+1], r_mem[hb]}; wv = {16'h0, h}; end
            6'h20: begin ld = 1; wr = rt; wv = {{24{r_mem[ba][7]}}, r_mem[ba]}; end
            6'h24: begin ld = 1; wr = rt; wv = {24'h0, r_mem[ba]}; end
            6'h2b: begin
                be = 4'hf; wd = b;
                if (!take) for (int i = 0; i < 4; i++) r_mem[wb + 8'(i)] = b[8*i +: 8];
            end
            6'h29: begin
                be = ea[1] ? 4'hc : 4'h3; wd = {b[15:0], b[15:0]};
                if (!take) begin r_mem[hb] = b[7:0]; r_mem[hb+1] = b[15:8]; end
            end
            6'h28: begin
                be = 4'b0001 << ba[1:0]; wd = {4{b[7:0]}};
                if (!take) r_mem[ba] = b[7:0];
            end
            default: ;
        endcase
`ifdef INT_EN
        if (inst == 32'h4200_0018) begin npc = r_epc; leave = 1'b1; end
`endif
        if (take) begin wr = 5'd0; be = 4'd0; npc = 32'h0000_4180; end

        check("pc", macroscopic_pc, r_pc);
        check("i_inst_addr", i_inst_addr, r_pc);
        check("m_inst_addr", m_inst_addr, r_pc);
        check("w_inst_addr", w_inst_addr, r_pc);
        check("grf_we", {31'd0, w_grf_we}, {31'd0, wr != 5'd0});
        if (wr != 5'd0) begin
            check("grf_addr", {27'd0, w_grf_addr}, {27'd0, wr});
            check("grf_wdata", w_grf_wdata, wv);
        end
        check("byteen", {28'd0, m_data_byteen}, {28'd0, be});
        if (be != 4'd0) begin
            check("st_addr", m_data_addr, ea);
            check("st_wdata", m_data_wdata, wd);
        end
        if (ld && !take) check("ld_addr", m_data_addr, ea);

        o_we = w_grf_we; o_wdata = w_grf_wdata; o_be = m_data_byteen; o_mwdata = m_data_wdata;

        if (wr != 5'd0) r_regs[wr] = wv;
        if (take) begin r_epc = r_pc; r_exl = 1'b1; end
        else if (leave) r_exl = 1'b0;
        r_pc = npc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; interrupt = 1'b0;
        i_inst_rdata = i_ins(6'h2b, 5'd0, 5'd2, 16'd4);   // a store sitting on the bus
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        check("rst_pc", macroscopic_pc, 32'h0000_3000);
        check("rst_byteen", {28'd0, m_data_byteen}, 32'd0);
        i_inst_rdata = i_ins(6'h0d, 5'd0, 5'd1, 16'h1234);
        #1;
        check("rst_grf_we", {31'd0, w_grf_we}, 32'd0);
        reset = 1'b1;
        r_pc = 32'h0000_3000; r_epc = 32'd0; r_exl = 1'b0;
        for (int i = 0; i < 32; i++) r_regs[i] = 32'd0;
    endtask

    function automatic logic [31:0] gen();
        logic [4:0]  s, t, d;
        logic [15:0] im;
        logic [7:0]  off;
        s = 5'($urandom_range(0, 7)); t = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
        im = 16'($urandom); off = 8'($urandom);
        case ($urandom_range(0, 24))
            0:  return r_ins(s, t, d, 5'd0, 6'h21);
            1:  return r_ins(s, t, d, 5'd0, 6'h23);
            2:  return r_ins(s, t, d, 5'd0, 6'h24);
            3:  return r_ins(s, t, d, 5'd0, 6'h25);
            4:  return r_ins(s, t, d, 5'd0, 6'h2a);
            5:  return r_ins(s, t, d, 5'd0, 6'h2b);
            6:  return r_ins(s, t, d, 5'($urandom_range(0, 31)), 6'h00);
            7:  return i_ins(6'h09, s, t, im);
            8:  return i_ins(6'h0c, s, t, im);
            9:  return i_ins(6'h0d, s, t, im);
            10: return i_ins(6'h0f, s, t, im);
            11: return i_ins(6'h04, s, t, 16'($urandom_range(0, 6)) - 16'd3);
            12: return i_ins(6'h05, s, t, 16'($urandom_range(0, 6)) - 16'd3);
            13: return {6'h02, 26'($urandom)};
            14: return {6'h03, 26'($urandom)};
            15: return r_ins(s, 5'd0, 5'd0, 5'd0, 6'h08);
            16: return i_ins(6'h23, 5'd0, t, {8'd0, off});
            17: return i_ins(6'h21, 5'd0, t, {8'd0, off});
            18: return i_ins(6'h25, 5'd0, t, {8'd0, off});
            19: return i_ins(6'h20, 5'd0, t, {8'd0, off});
            20: return i_ins(6'h24, 5'd0, t, {8'd0, off});
            21: return i_ins(6'h2b, 5'd0, t, {8'd0, off});
            22: return i_ins(6'h29, 5'd0, t, {8'd0, off});
            23: return i_ins(6'h28, 5'd0, t, {8'd0, off});
            default: case ($urandom_range(0, 3))
                0:       return 32'd0;
                1:       return 32'h4200_0018;
                2:       return {6'h3f, 26'($urandom)};
                default: return r_ins(s, t, d, 5'd0, 6'h3f);
            endcase
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 64; i++)  env_mem[i] = 32'd0;
        for (int i = 0; i < 256; i++) r_mem[i] = 8'd0;

        // Directed: arithmetic, stores and sub-word loads.
        do_reset();
        run(i_ins(6'h0d, 5'd0, 5'd1, 16'h1234), 1'b0);
        check("plan_ori_we", {31'd0, o_we}, 32'd1);
        check("plan_ori_wdata", o_wdata, 32'h0000_1234);
        run(i_ins(6'h0f, 5'd0, 5'd2, 16'h8000), 1'b0);
        run(i_ins(6'h0d, 5'd2, 5'd2, 16'h00ff), 1'b0);
        run(i_ins(6'h2b, 5'd0, 5'd2, 16'd4), 1'b0);
        check("plan_sw_be", {28'd0, o_be}, 32'hf);
        check("plan_sw_wdata", o_mwdata, 32'h8000_00ff);
        run(i_ins(6'h28, 5'd0, 5'd2, 16'd7), 1'b0);
        check("plan_sb_be", {28'd0, o_be}, 32'h8);
        check("plan_sb_wdata", o_mwdata, 32'hffff_ffff);
        run(i_ins(6'h20, 5'd0, 5'd3, 16'd7), 1'b0);
        check("plan_lb", o_wdata, 32'hffff_ffff);
        run(i_ins(6'h24, 5'd0, 5'd4, 16'd7), 1'b0);
        check("plan_lbu", o_wdata, 32'h0000_00ff);
        run(i_ins(6'h29, 5'd0, 5'd2, 16'd2), 1'b0);
        check("plan_sh_be", {28'd0, o_be}, 32'hc);
        check("plan_sh_wdata", o_mwdata, 32'h00ff_00ff);
        run(i_ins(6'h25, 5'd0, 5'd5, 16'd2), 1'b0);
        check("plan_lhu", o_wdata, 32'h0000_00ff);

        // Directed: control flow and register-zero handling.
        do_reset();
        for (int i = 0; i < 4; i++) run(32'd0, 1'b0);
        run(i_ins(6'h04, 5'd0, 5'd0, 16'd2), 1'b0);
        check("plan_beq_pc", macroscopic_pc, 32'h0000_301c);
        run(i_ins(6'h05, 5'd0, 5'd0, 16'd2), 1'b0);
        check("plan_bne_pc", macroscopic_pc, 32'h0000_3020);
        run({6'h03, 26'h0000c40}, 1'b0);
        check("plan_jal_ra", o_wdata, 32'h0000_3024);
        check("plan_jal_pc", macroscopic_pc, 32'h0000_3100);
        run(r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 1'b0);
        check("plan_jr_pc", macroscopic_pc, 32'h0000_3024);
        run(i_ins(6'h09, 5'd0, 5'd1, 16'd0), 1'b0);
        check("plan_addiu0_we", {31'd0, o_we}, 32'd1);
        check("plan_addiu0_wdata", o_wdata, 32'd0);
        run(i_ins(6'h0d, 5'd0, 5'd0, 16'd5), 1'b0);
        check("plan_r0_we", {31'd0, o_we}, 32'd0);
        run(r_ins(5'd0, 5'd0, 5'd10, 5'd0, 6'h21), 1'b0);
        check("plan_r0_zero", o_wdata, 32'd0);
        run(i_ins(6'h09, 5'd0, 5'd6, 16'hffff), 1'b0);
        run(i_ins(6'h09, 5'd0, 5'd7, 16'd1), 1'b0);
        run(r_ins(5'd6, 5'd7, 5'd8, 5'd0, 6'h2a), 1'b0);
        check("plan_slt", o_wdata, 32'd1);
        run(r_ins(5'd6, 5'd7, 5'd9, 5'd0, 6'h2b), 1'b0);
        check("plan_sltu", o_wdata, 32'd0);

`ifdef INT_EN
        // Directed: interrupt squash, masking under EXL, and eret return.
        do_reset();
        run(32'd0, 1'b0);
        run(32'd0, 1'b0);
        run(i_ins(6'h2b, 5'd0, 5'd2, 16'd4), 1'b1);
        check("plan_int_be", {28'd0, o_be}, 32'd0);
        check("plan_int_pc", macroscopic_pc, 32'h0000_4180);
        run(32'd0, 1'b1);
        check("plan_int_masked", macroscopic_pc, 32'h0000_4184);
        run(32'h4200_0018, 1'b0);
        check("plan_eret_pc", macroscopic_pc, 32'h0000_3008);
        run(i_ins(6'h2b, 5'd0, 5'd2, 16'd4), 1'b0);
        check("plan_sw_after_eret", {28'd0, o_be}, 32'hf);
`endif

        // Random instruction stream with occasional interrupt requests.
        do_reset();
        for (int n = 0; n < 600; n++) run(gen(), $urandom_range(0, 9) == 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
